tx_packet_fifo: RTL and testbench

//  Single-clock, parametrised transmit FIFO with packet retry, for endpoints whose bus and USB logic share one clock.
//  Bus side pushes words. The USB side pops them and then either acknowledges the packet (space released) or requests a retry.
//  A retry rewinds the read pointer to the first unacknowledged word, so the packet is resent after a missing handshake.

---
 rtl/tx_packet_fifo_pkg.sv | 14 +
 rtl/tx_fifo_ram.sv | 38 +++
 rtl/tx_packet_fifo.sv | 124 ++++++++++++
 tb/tb_tx_packet_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_packet_fifo_pkg.sv
// Shared defaults and flag bit positions for the single-clock transmit FIFO
// with packet retry.
package tx_packet_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam bit DEFAULT_PKT_MODE   = 1'b1;

    // Bit positions inside the sticky error flag vector
    localparam int FLAG_OVERFLOW_BIT  = 0;
    localparam int FLAG_UNDERFLOW_BIT = 1;
    localparam int FLAG_COUNT         = 2;

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port storage for the transmit FIFO: synchronous write and a
// registered, read-enabled read port. The array itself is not reset.
module tx_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value until the next enabled read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tx_packet_fifo.sv
// Single-clock transmit FIFO with packet acknowledge / retry. Read words stay
// reserved until acknowledged so a lost packet can be replayed.
module tx_packet_fifo
    import tx_packet_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter bit PKT_MODE   = DEFAULT_PKT_MODE
) (
    input  logic                  busClk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  fifoFull,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  fifoEmpty,
    input  logic                  pktAck,
    input  logic                  pktRetry,
    input  logic                  forceEmpty,
    input  logic                  clrFlags,
    output logic [ADDR_WIDTH:0]   numElementsInFifo,
    output logic [ADDR_WIDTH:0]   freeSpace,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         rel_ptr_q, rel_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic [PW-1:0]         free_q, free_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [FLAG_COUNT-1:0] err_q, err_d;
    logic                  ack_s, retry_s, push_ok_s, pop_ok_s;
    logic [PW-1:0]         rd_adv_s;

    // Pointer, status and sticky-flag next state
    always_comb begin
        ack_s     = PKT_MODE & pktAck;
        retry_s   = PKT_MODE & pktRetry & ~pktAck;
        push_ok_s = wrEn & ~full_q & ~forceEmpty;
        pop_ok_s  = rdEn & ~empty_q & ~retry_s & ~forceEmpty;
        rd_adv_s  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rel_ptr_d = rel_ptr_q;
        err_d     = err_q;
        if (forceEmpty) begin
            wr_ptr_d  = {PW{1'b0}};
            rd_ptr_d  = {PW{1'b0}};
            rel_ptr_d = {PW{1'b0}};
            err_d     = {FLAG_COUNT{1'b0}};
        end else begin
            wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_adv_s = pop_ok_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            rd_ptr_d = retry_s ? rel_ptr_q : rd_adv_s;
            // Without packet mode every read releases its slot immediately
            if (!PKT_MODE || ack_s) begin
                rel_ptr_d = rd_adv_s;
            end else begin
                rel_ptr_d = rel_ptr_q;
            end
            err_d[FLAG_OVERFLOW_BIT]  = (wrEn & full_q) |
                                        (err_q[FLAG_OVERFLOW_BIT] & ~clrFlags);
            err_d[FLAG_UNDERFLOW_BIT] = (rdEn & empty_q & ~retry_s) |
                                        (err_q[FLAG_UNDERFLOW_BIT] & ~clrFlags);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = ((wr_ptr_d - rel_ptr_d) == DEPTH);
        count_d = wr_ptr_d - rd_ptr_d;
        free_d  = DEPTH - (wr_ptr_d - rel_ptr_d);
    end

    // State and registered status outputs
    always_ff @(posedge busClk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            rel_ptr_q <= {PW{1'b0}};
            count_q   <= {PW{1'b0}};
            free_q    <= DEPTH;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            err_q     <= {FLAG_COUNT{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rel_ptr_q <= rel_ptr_d;
            count_q   <= count_d;
            free_q    <= free_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            err_q     <= err_d;
        end
    end

    tx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (busClk),
        .rst_i     (rst),
        .wr_en_i   (push_ok_s),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wrData),
        .rd_en_i   (pop_ok_s),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (rdData)
    );

    assign fifoEmpty         = empty_q;
    assign fifoFull          = full_q;
    assign numElementsInFifo = count_q;
    assign freeSpace         = free_q;
    assign overflow          = err_q[FLAG_OVERFLOW_BIT];
    assign underflow         = err_q[FLAG_UNDERFLOW_BIT];

endmodule

// File: tb/tb_tx_packet_fifo.sv
// Bench for tx_packet_fifo: a plain-FIFO and a packet-mode instance share the
// same stimulus and are compared every cycle against an unbounded-counter model.
module tb_tx_packet_fifo;

    localparam int DEPTH = 64;
    localparam int HSZ   = 4096;

    logic       bus_clk;
    logic       rst;
    logic       wr_en, rd_en, pkt_ack, pkt_retry, force_empty, clr_flags;
    logic [7:0] wr_data;

    logic [1:0][7:0] rd_data_w;
    logic [1:0][6:0] num_w, free_w;
    logic [1:0]      empty_w, full_w, ov_w, un_w;

    // Model: absolute write/read/release counts and the history of pushed words
    int         wc [2];
    int         rc [2];
    int         lc [2];
    bit         mov [2];
    bit         mun [2];
    logic [7:0] rdd [2];
    logic [7:0] hist [0:1][0:HSZ-1];

    int n_checks = 0;
    int n_errors = 0;

    tx_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .PKT_MODE(1'b0)) u_dut_raw (
        .busClk(bus_clk), .rst(rst), .wrEn(wr_en), .wrData(wr_data),
        .fifoFull(full_w[0]), .rdEn(rd_en), .rdData(rd_data_w[0]),
        .fifoEmpty(empty_w[0]), .pktAck(pkt_ack), .pktRetry(pkt_retry),
        .forceEmpty(force_empty), .clrFlags(clr_flags),
        .numElementsInFifo(num_w[0]), .freeSpace(free_w[0]),
        .overflow(ov_w[0]), .underflow(un_w[0])
    );

    tx_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .PKT_MODE(1'b1)) u_dut_pkt (
        .busClk(bus_clk), .rst(rst), .wrEn(wr_en), .wrData(wr_data),
        .fifoFull(full_w[1]), .rdEn(rd_en), .rdData(rd_data_w[1]),
        .fifoEmpty(empty_w[1]), .pktAck(pkt_ack), .pktRetry(pkt_retry),
        .forceEmpty(force_empty), .clrFlags(clr_flags),
        .numElementsInFifo(num_w[1]), .freeSpace(free_w[1]),
        .overflow(ov_w[1]), .underflow(un_w[1])
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    task automatic check_eq(input string tag, input int obs, input int expected);
        n_checks++;
        if (obs != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expected);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            wc[m] = 0; rc[m] = 0; lc[m] = 0;
            mov[m] = 1'b0; mun[m] = 1'b0; rdd[m] = 8'h00;
        end
    endtask

    // One clock edge of the reference behaviour; decisions use pre-edge state
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit full, empty, ack, retry, push, pop;
            full  = ((wc[m] - lc[m]) == DEPTH);
            empty = ((wc[m] - rc[m]) == 0);
            if (force_empty) begin
                rc[m] = wc[m]; lc[m] = wc[m];
                mov[m] = 1'b0; mun[m] = 1'b0;
            end else begin
                ack   = (m == 1) && pkt_ack;
                retry = (m == 1) && pkt_retry && !pkt_ack;
                push  = wr_en && !full;
                pop   = rd_en && !empty && !retry;
                if (clr_flags) begin
                    mov[m] = 1'b0; mun[m] = 1'b0;
                end
                if (wr_en && full) mov[m] = 1'b1;
                if (rd_en && empty && !retry) mun[m] = 1'b1;
                if (push) begin
                    hist[m][wc[m] % HSZ] = wr_data;
                    wc[m]++;
                end
                if (pop) begin
                    rdd[m] = hist[m][rc[m] % HSZ];
                    rc[m]++;
                end
                if (retry) rc[m] = lc[m];
                if (m == 0 || ack) lc[m] = rc[m];
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("m%0d_rdData", m), int'(rd_data_w[m]), int'(rdd[m]));
            check_eq($sformatf("m%0d_empty", m), int'(empty_w[m]), (wc[m] == rc[m]) ? 1 : 0);
            check_eq($sformatf("m%0d_full", m), int'(full_w[m]), ((wc[m] - lc[m]) == DEPTH) ? 1 : 0);
            check_eq($sformatf("m%0d_num", m), int'(num_w[m]), wc[m] - rc[m]);
            check_eq($sformatf("m%0d_free", m), int'(free_w[m]), DEPTH - (wc[m] - lc[m]));
            check_eq($sformatf("m%0d_overflow", m), int'(ov_w[m]), int'(mov[m]));
            check_eq($sformatf("m%0d_underflow", m), int'(un_w[m]), int'(mun[m]));
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; pkt_ack = 1'b0; pkt_retry = 1'b0;
        force_empty = 1'b0; clr_flags = 1'b0;
    endtask

    // Assert reset between edges and check that outputs react before any edge
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("arst_empty", int'(empty_w[1]), 1);
        check_eq("arst_free", int'(free_w[1]), 64);
        check_eq("arst_rdData", int'(rd_data_w[1]), 0);
        @(posedge bus_clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_data = 8'h00;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge bus_clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Fill to full, overflow on the extra word, then drain in order
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_data = i[7:0]; step();
        end
        check_eq("fill_full_raw", int'(full_w[0]), 1);
        check_eq("fill_full_pkt", int'(full_w[1]), 1);
        wr_data = 8'hFF; step();
        wr_en = 1'b0;
        check_eq("ovf_raw", int'(ov_w[0]), 1);
        check_eq("ovf_pkt", int'(ov_w[1]), 1);
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            check_eq("drain_data", int'(rd_data_w[0]), i);
        end
        rd_en = 1'b0;
        check_eq("drain_empty_raw", int'(empty_w[0]), 1);
        check_eq("drain_free_raw", int'(free_w[0]), 64);
        check_eq("drain_free_pkt", int'(free_w[1]), 0);
        pkt_ack = 1'b1; step(); pkt_ack = 1'b0;
        check_eq("ack_free_pkt", int'(free_w[1]), 64);
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        check_eq("clr_ovf_pkt", int'(ov_w[1]), 0);

        // Retry replays the unacknowledged packet
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + i[7:0]; step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        repeat (8) step();
        rd_en = 1'b0;
        pkt_retry = 1'b1; step(); pkt_retry = 1'b0;
        check_eq("retry_num", int'(num_w[1]), 8);
        check_eq("retry_free", int'(free_w[1]), 56);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pkt_ack = (i == 7);
            step();
            check_eq("replay_data", int'(rd_data_w[1]), 160 + i);
        end
        rd_en = 1'b0; pkt_ack = 1'b0;
        check_eq("ack_last_free", int'(free_w[1]), 64);
        check_eq("ack_last_empty", int'(empty_w[1]), 1);

        // Wrap: move pointers to 60, then stream 8 words across the boundary
        force_empty = 1'b1; step(); force_empty = 1'b0;
        for (int i = 0; i < 60; i++) begin
            wr_en = 1'b1; wr_data = i[7:0]; step();
        end
        wr_en = 1'b0; rd_en = 1'b1; pkt_ack = 1'b1;
        repeat (60) step();
        rd_en = 1'b0; pkt_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + i[7:0]; step();
        end
        wr_en = 1'b0; rd_en = 1'b1; pkt_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("wrap_data", int'(rd_data_w[1]), 192 + i);
        end
        rd_en = 1'b0; pkt_ack = 1'b0;
        check_eq("wrap_empty", int'(empty_w[1]), 1);

        // forceEmpty beats simultaneous push/pop and clears flags
        rd_en = 1'b1; step(); rd_en = 1'b0;
        check_eq("unf_set", int'(un_w[1]), 1);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + i[7:0]; step();
        end
        force_empty = 1'b1; wr_en = 1'b1; rd_en = 1'b1; step();
        idle_inputs();
        check_eq("flush_num", int'(num_w[1]), 0);
        check_eq("flush_free", int'(free_w[1]), 64);
        check_eq("flush_unf", int'(un_w[1]), 0);

        // pktAck together with pktRetry: ack wins and includes the same-cycle pop
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hD0 + i[7:0]; step();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        repeat (2) step();
        pkt_ack = 1'b1; pkt_retry = 1'b1; step();
        idle_inputs();
        check_eq("ackretry_num", int'(num_w[1]), 1);
        check_eq("ackretry_free", int'(free_w[1]), 63);
        check_eq("ackretry_data", int'(rd_data_w[1]), 210);

        // Randomised traffic with an asynchronous reset partway through
        for (int c = 0; c < 3000; c++) begin
            wr_en       = ($urandom_range(0, 99) < 60);
            rd_en       = ($urandom_range(0, 99) < 50);
            pkt_ack     = ($urandom_range(0, 99) < 8);
            pkt_retry   = ($urandom_range(0, 99) < 8);
            force_empty = ($urandom_range(0, 199) < 2);
            clr_flags   = ($urandom_range(0, 99) < 5);
            wr_data     = 8'($urandom);
            if (c == 1500) begin
                async_reset();
            end else begin
                step();
            end
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
